// File: rtl/tag_arb_pkg.sv
// Shared constants and types for the 16x16 tag crossbar output side.
// Tag layout, MSB to LSB: {pri[2:0], addr+len, srcPort[3:0]}.
package tag_arb_pkg;

  localparam int N_IN       = 16;
  localparam int DST_W      = 4;
  localparam int ADDR_LENTH = 16;
  localparam int TAG_W      = ADDR_LENTH + 11;

  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [DST_W-1:0] port_t;

  localparam int SRC_LSB = 0;
  localparam int MSG_LSB = DST_W;
  localparam int PRI_LSB = TAG_W - 3;

  function automatic logic [2:0] tagPri(input tag_t tag);
    return tag[PRI_LSB +: 3];
  endfunction

endpackage

// File: rtl/tag_port_arbiter_rr_pick.sv
// Rotating-priority picker: first set bit of eligible at or after ptr, modulo N_IN.
// The vector is doubled so the wrap-around search becomes a plain lowest-bit find.
module rr_pick #(
  parameter int N_IN  = 16,
  parameter int DST_W = 4
) (
  input  logic [N_IN-1:0]  eligible,
  input  logic [DST_W-1:0] ptr,
  output logic [DST_W-1:0] gnt,
  output logic             anyVld
);

  logic [2*N_IN-1:0] masked;

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : gMask
      // Lower copy only holds bits at or above ptr; upper copy covers the wrap.
      assign masked[gi]        = eligible[gi] && (DST_W'(gi) >= ptr);
      assign masked[gi + N_IN] = eligible[gi];
    end
  endgenerate

  always_comb begin
    gnt    = '0;
    anyVld = |eligible;
    for (int j = 2 * N_IN - 1; j >= 0; j--) begin
      if (masked[j]) gnt = DST_W'(j % N_IN);
    end
  end

endmodule

// File: rtl/tag_port_arbiter.sv
// Per-output-port scheduler: round-robin picks among inputs addressed to PORT_ID,
// registers the winner in a single-entry output stage, and counts delivered tags.
module tag_port_arbiter #(
  parameter int N_IN    = tag_arb_pkg::N_IN,
  parameter int TAG_W   = tag_arb_pkg::TAG_W,
  parameter int DST_W   = tag_arb_pkg::DST_W,
  parameter int PORT_ID = 0
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic [N_IN-1:0]       iReqVld,
  input  logic [N_IN*DST_W-1:0] iReqDst,
  input  logic [N_IN*TAG_W-1:0] iReqPld,
  output logic [N_IN-1:0]       oReqRdy,
  output logic                  oTagVld,
  output logic [TAG_W-1:0]      oTagPld,
  output logic [DST_W-1:0]      oTagSrc,
  input  logic                  iTagRdy,
  output logic [15:0]           oTagCnt
);

  localparam logic [DST_W-1:0] MY_ID = DST_W'(PORT_ID);

  logic [N_IN-1:0]  eligible;
  logic [DST_W-1:0] gnt;
  logic [DST_W-1:0] ptrReg;
  logic             anyVld;
  logic             load;
  logic             outHs;

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : gElig
      assign eligible[gi] = iReqVld[gi] && (iReqDst[gi*DST_W +: DST_W] == MY_ID);
      assign oReqRdy[gi]  = load && (gnt == DST_W'(gi));
    end
  endgenerate

  rr_pick #(
    .N_IN  (N_IN),
    .DST_W (DST_W)
  ) uPick (
    .eligible (eligible),
    .ptr      (ptrReg),
    .gnt      (gnt),
    .anyVld   (anyVld)
  );

  // Gating with iRst keeps every ready low while the stage is being cleared.
  assign load  = anyVld && (!oTagVld || iTagRdy) && !iRst;
  assign outHs = oTagVld && iTagRdy;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      oTagVld <= 1'b0;
      oTagPld <= '0;
      oTagSrc <= '0;
      ptrReg  <= '0;
      oTagCnt <= '0;
    end else begin
      if (load) begin
        oTagVld <= 1'b1;
        oTagPld <= iReqPld[gnt*TAG_W +: TAG_W];
        oTagSrc <= gnt;
        ptrReg  <= gnt + 1'b1;
      end else if (outHs) begin
        oTagVld <= 1'b0;
      end
      if (outHs && (oTagCnt != 16'hFFFF)) oTagCnt <= oTagCnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_tag_port_arbiter.sv
// Two arbiter instances (ports 0 and 3) on shared inputs, checked against a
// per-port scheduling model: directed scenarios, a random phase, then saturation.
module tb_tag_port_arbiter;

  localparam int NI = 16;
  localparam int TW = 27;
  localparam int DW = 4;
  localparam int PID [2] = '{0, 3};

  logic clk = 1'b0;
  logic rst;
  logic tagRdy;
  always #5 clk = ~clk;

  logic          vld [NI];
  logic [DW-1:0] dst [NI];
  logic [TW-1:0] pld [NI];

  logic [NI-1:0]    reqVld;
  logic [NI*DW-1:0] reqDst;
  logic [NI*TW-1:0] reqPld;

  always_comb begin
    reqVld = '0;
    reqDst = '0;
    reqPld = '0;
    for (int i = 0; i < NI; i++) begin
      reqVld[i]           = vld[i];
      reqDst[i*DW +: DW]  = dst[i];
      reqPld[i*TW +: TW]  = pld[i];
    end
  end

  logic [NI-1:0] rdy  [2];
  logic          oVld [2];
  logic [TW-1:0] oPld [2];
  logic [DW-1:0] oSrc [2];
  logic [15:0]   oCnt [2];

  tag_port_arbiter #(.N_IN(NI), .TAG_W(TW), .DST_W(DW), .PORT_ID(0)) u0 (
    .iClk(clk), .iRst(rst), .iReqVld(reqVld), .iReqDst(reqDst), .iReqPld(reqPld),
    .oReqRdy(rdy[0]), .oTagVld(oVld[0]), .oTagPld(oPld[0]), .oTagSrc(oSrc[0]),
    .iTagRdy(tagRdy), .oTagCnt(oCnt[0]));

  tag_port_arbiter #(.N_IN(NI), .TAG_W(TW), .DST_W(DW), .PORT_ID(3)) u3 (
    .iClk(clk), .iRst(rst), .iReqVld(reqVld), .iReqDst(reqDst), .iReqPld(reqPld),
    .oReqRdy(rdy[1]), .oTagVld(oVld[1]), .oTagPld(oPld[1]), .oTagSrc(oSrc[1]),
    .iTagRdy(tagRdy), .oTagCnt(oCnt[1]));

  int nAsserts = 0;
  int nFails   = 0;

  // Model state: which input the port would serve next, and what it holds.
  int      mPtr [2];
  bit      mVld [2];
  int      mPld [2];
  int      mSrc [2];
  int      mCnt [2];
  bit      granted [NI];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAsserts++;
    assert (act === exp) else begin
      nFails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int winner(input int k);
    for (int off = 0; off < NI; off++) begin
      int idx = (mPtr[k] + off) % NI;
      if (vld[idx] && (int'(dst[idx]) == PID[k])) return idx;
    end
    return -1;
  endfunction

  // One clock: check readies before the edge, advance the model, check outputs after.
  task automatic step();
    int  w  [2];
    bit  ld [2];
    @(negedge clk);
    for (int i = 0; i < NI; i++) granted[i] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      w[k]  = winner(k);
      ld[k] = (w[k] >= 0) && (!mVld[k] || tagRdy) && !rst;
      check($sformatf("rdy_p%0d", PID[k]), 32'(rdy[k]), ld[k] ? (32'd1 << w[k]) : 32'd0);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mVld[k] = 0; mPld[k] = 0; mSrc[k] = 0; mPtr[k] = 0; mCnt[k] = 0;
      end else begin
        bit hs = mVld[k] && tagRdy;
        if (hs && mCnt[k] < 65535) mCnt[k]++;
        if (ld[k]) begin
          mVld[k] = 1; mPld[k] = int'(pld[w[k]]); mSrc[k] = w[k];
          mPtr[k] = (w[k] + 1) % NI;
          granted[w[k]] = 1'b1;
        end else if (hs) begin
          mVld[k] = 0;
        end
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("vld_p%0d", PID[k]), 32'(oVld[k]), 32'(mVld[k]));
      check($sformatf("pld_p%0d", PID[k]), 32'(oPld[k]), mPld[k]);
      check($sformatf("src_p%0d", PID[k]), 32'(oSrc[k]), mSrc[k]);
      check($sformatf("cnt_p%0d", PID[k]), 32'(oCnt[k]), mCnt[k]);
    end
  endtask

  task automatic clearInputs();
    for (int i = 0; i < NI; i++) begin
      vld[i] = 1'b0; dst[i] = '0; pld[i] = '0;
    end
  endtask

  task automatic doReset();
    clearInputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tagRdy = 1'b0;
    clearInputs();
    for (int k = 0; k < 2; k++) begin
      mVld[k] = 0; mPld[k] = 0; mSrc[k] = 0; mPtr[k] = 0; mCnt[k] = 0;
    end

    // Reset state
    doReset();
    check("reset_vld", 32'(oVld[0]), 0);
    check("reset_cnt", 32'(oCnt[0]), 0);

    // Single requester
    tagRdy = 1'b1;
    vld[0] = 1'b1; dst[0] = 4'd0; pld[0] = 27'h1;
    step();
    check("single_vld", 32'(oVld[0]), 1);
    check("single_pld", 32'(oPld[0]), 1);
    check("single_src", 32'(oSrc[0]), 0);
    vld[0] = 1'b0;
    step();
    check("single_cnt", 32'(oCnt[0]), 1);
    $display("txn single_requester src=%0d cnt=%0d", oSrc[0], oCnt[0]);

    // Full contention at port 3
    doReset();
    tagRdy = 1'b1;
    for (int i = 0; i < NI; i++) begin
      vld[i] = 1'b1; dst[i] = 4'd3; pld[i] = TW'(i);
    end
    for (int j = 0; j < 17; j++) begin
      step();
      check("contend_src", 32'(oSrc[1]), j % NI);
      check("contend_vld", 32'(oVld[1]), 1);
      $display("txn contention cycle=%0d src=%0d", j, oSrc[1]);
    end
    check("contend_cnt", 32'(oCnt[1]), 16);

    // Backpressure: input 2 held, input 7 waits, then loads with no bubble
    doReset();
    tagRdy = 1'b0;
    vld[2] = 1'b1; dst[2] = 4'd0; pld[2] = 27'h222;
    vld[7] = 1'b1; dst[7] = 4'd0; pld[7] = 27'h777;
    step();
    vld[2] = 1'b0;
    for (int j = 0; j < 5; j++) begin
      step();
      check("bp_pld", 32'(oPld[0]), 32'h222);
      check("bp_rdy", 32'(rdy[0]), 0);
    end
    tagRdy = 1'b1;
    step();
    check("bp_src", 32'(oSrc[0]), 7);
    check("bp_vld", 32'(oVld[0]), 1);
    check("bp_cnt", 32'(oCnt[0]), 1);
    $display("txn backpressure src=%0d pld=0x%0h", oSrc[0], oPld[0]);

    // Destination filtering
    doReset();
    tagRdy = 1'b1;
    vld[4] = 1'b1; dst[4] = 4'd1; pld[4] = 27'h44;
    vld[5] = 1'b1; dst[5] = 4'd0; pld[5] = 27'h55;
    for (int j = 0; j < 20; j++) begin
      step();
      check("filt_rdy4", 32'(rdy[0][4]), 0);
      check("filt_src", 32'(oSrc[0]), 5);
    end
    $display("txn dst_filter src=%0d", oSrc[0]);

    // Pointer wrap and idle cycles
    doReset();
    tagRdy = 1'b1;
    vld[15] = 1'b1; dst[15] = 4'd0; pld[15] = 27'hF;
    step();
    vld[15] = 1'b0;
    for (int j = 0; j < 3; j++) step();
    vld[0]  = 1'b1; dst[0]  = 4'd0; pld[0]  = 27'h100;
    vld[14] = 1'b1; dst[14] = 4'd0; pld[14] = 27'h114;
    step();
    check("wrap_first", 32'(oSrc[0]), 0);
    vld[0] = 1'b0;
    step();
    check("wrap_second", 32'(oSrc[0]), 14);
    vld[14] = 1'b0;
    step();
    $display("txn ptr_wrap second=%0d", oSrc[0]);

    // Reset while holding a tag under backpressure
    doReset();
    tagRdy = 1'b0;
    vld[3] = 1'b1; dst[3] = 4'd3; pld[3] = 27'h333;
    step();
    vld[3] = 1'b0;
    step();
    check("hold_vld", 32'(oVld[1]), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_vld", 32'(oVld[1]), 0);
    check("rst_cnt", 32'(oCnt[1]), 0);
    tagRdy = 1'b1;
    vld[0]  = 1'b1; dst[0]  = 4'd3; pld[0]  = 27'hA0;
    vld[15] = 1'b1; dst[15] = 4'd3; pld[15] = 27'hAF;
    step();
    check("rst_ptr", 32'(oSrc[1]), 0);
    $display("txn reset_mid_hold src=%0d", oSrc[1]);

    // Random traffic with legal requester behaviour
    doReset();
    for (int c = 0; c < 600; c++) begin
      tagRdy = ($urandom_range(0, 3) != 0);
      rst    = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < NI; i++) begin
        if (vld[i] && !granted[i]) begin
          if ($urandom_range(0, 7) == 0) vld[i] = 1'b0;
        end else if ($urandom_range(0, 1) == 0) begin
          vld[i] = 1'b1;
          dst[i] = DW'($urandom_range(0, 4));
          pld[i] = TW'($urandom);
        end else begin
          vld[i] = 1'b0;
        end
      end
      step();
      if (c % 50 == 0)
        $display("txn random cycle=%0d p0_src=%0d p3_src=%0d", c, oSrc[0], oSrc[1]);
    end
    rst = 1'b0;

    // Counter saturation
    doReset();
    tagRdy = 1'b1;
    vld[0] = 1'b1; dst[0] = 4'd0; pld[0] = 27'h5A;
    vld[1] = 1'b1; dst[1] = 4'd3; pld[1] = 27'hA5;
    for (int j = 0; j < 65538; j++) step();
    check("sat_cnt0", 32'(oCnt[0]), 32'hFFFF);
    check("sat_cnt3", 32'(oCnt[1]), 32'hFFFF);
    $display("txn saturation cnt=0x%0h", oCnt[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/tag_port_arbiter.md
Name: tag_port_arbiter

Overview:
- Per-output-port scheduler for the 16x16 tag crossbar.
- Round-robin arbitrates the 16 decoupled tag inputs whose Dst field equals this port's ID.
- Registers the winner into a single-entry output stage and presents it on a decoupled Vld/Rdy output.
- Sixteen instances, one per PORT_ID, form the crossbar's output side; this block also keeps a per-port accepted-tag counter for debug.

Parameters:
- N_IN, 16, number of requesting input ports (power of two).
- TAG_W, 27, tag payload width (ADDR_LENTH 16 + 11: {pri[2:0], addr+len, srcPort[3:0]}).
- DST_W, 4, destination/source index width, log2(N_IN).
- PORT_ID, 0, output port index this instance serves.

Ports:
- iClk  in  1  clock; single clock domain.
- iRst  in  1  reset; synchronous, active-high.
- iReqVld  in  N_IN  per-input tag valid.
- iReqDst  in  N_IN*DST_W  per-input destination; slice i = [i*DST_W +: DST_W].
- iReqPld  in  N_IN*TAG_W  per-input tag payload; slice i = [i*TAG_W +: TAG_W].
- oReqRdy  out  N_IN  per-input ready; one-hot or zero.
- oTagVld  out  1  output tag valid.
- oTagPld  out  TAG_W  output tag payload.
- oTagSrc  out  DST_W  index of the input that supplied the output tag.
- iTagRdy  in  1  downstream ready.
- oTagCnt  out  16  count of tags accepted at the output handshake; saturates at 0xFFFF.

Behaviour:
- Eligibility: input i is eligible when iReqVld[i]=1 and iReqDst[i]=PORT_ID.
- Input protocol: requesters hold Pld and Dst stable while Vld=1 until their handshake. Vld may drop without a handshake; the arbiter must not latch stale data in that case.
- Output stage: one register (FULL/EMPTY, encoded by oTagVld).
  - load = any eligible AND (oTagVld=0 OR iTagRdy=1). This gives full throughput of one tag per cycle under continuous iTagRdy.
- Pick: combinational rotating-priority search starting at pointer ptr (DST_W bits). The first eligible index at or after ptr, modulo N_IN, wins (gnt).
- oReqRdy[gnt]=1 only when load=1 in that cycle; all other bits are 0. Input handshake = iReqVld[gnt] & oReqRdy[gnt].
- On load at edge k:
  - oTagPld <= iReqPld[gnt]; oTagSrc <= gnt; oTagVld <= 1.
  - ptr <= gnt+1, wrapping from N_IN-1 to 0.
  - Latency: input handshake at edge k gives oTagVld=1 in cycle k+1.
- Output handshake (oTagVld & iTagRdy) with no load in the same cycle: oTagVld <= 0.
- Output handshake and load in the same cycle: the register is overwritten with the new tag and oTagVld stays 1.
- Backpressure: oTagVld=1 and iTagRdy=0 means the register holds, every oReqRdy=0, and ptr holds.
- Pointer: ptr is unchanged when no load occurs, so an idle cycle does not advance fairness.
- oTagCnt: increments on each output handshake and saturates at 0xFFFF (no wrap).
- Mismatched Dst: inputs with iReqDst != PORT_ID are never granted and always see oReqRdy=0 from this instance.
- Reset: iRst=1 at an edge clears oTagVld, oTagPld, oTagSrc, ptr and oTagCnt to 0. While iRst=1, oReqRdy is forced to 0 combinationally.
- Reset mid-transfer: a held tag is dropped. Upstream re-presents it, which is legal because no input handshake occurred for it.
- Fairness bound: with all N_IN inputs continuously eligible and iTagRdy=1, each input is granted exactly once per N_IN cycles.

Decomposition:
- Package tag_arb_pkg:
  - constants N_IN, DST_W, TAG_W;
  - typedefs tag_t (logic[TAG_W-1:0]) and port_t (logic[DST_W-1:0]);
  - the payload field offsets PRI_LSB, MSG_LSB, SRC_LSB.
- Sub-module rr_pick (purely combinational, N_IN parameter):
  - inputs: eligible vector and ptr;
  - outputs: gnt index and anyVld;
  - implementation: double-width masked priority encoder.
- tag_port_arbiter instantiates rr_pick and owns ptr, the output register and the counter.

Test Plan:
- Single requester: PORT_ID=0, input 0 sends Dst=0 with Pld=0x1, iTagRdy=1 -> oReqRdy[0]=1 in the same cycle; next cycle oTagVld=1, oTagPld=0x1, oTagSrc=0; oTagCnt=1.
- Full contention: all 16 inputs with Dst=PORT_ID=3, Pld=index, iTagRdy=1 -> oTagSrc sequence 0,1,...,15,0 on consecutive cycles; no gaps; after 16 cycles oTagCnt=16.
- Backpressure: hold iTagRdy=0 for 5 cycles with inputs 2 and 7 eligible -> oTagPld frozen at input 2's tag, every oReqRdy=0; on iTagRdy=1, input 7 loads in the same cycle with no bubble.
- Dst filtering: inputs 4 (Dst=1) and 5 (Dst=0) valid at PORT_ID=0 -> only input 5 is granted; oReqRdy[4] stays 0 for 20 cycles.
- Pointer wrap and idle: grant input 15, idle 3 cycles, then inputs 0 and 14 eligible -> input 0 wins first, then input 14.
- Reset mid-hold and saturation: assert iRst with oTagVld=1 and iTagRdy=0 -> next cycle oTagVld=0, oTagCnt=0, ptr=0. Preload the counter to 0xFFFE via 0xFFFE handshakes, then 3 more -> oTagCnt=0xFFFF.
